seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx_pkg.sv | 13 +
 rtl/seq_pattern_tx_if.sv | 30 +++
 rtl/seq_pattern_tx_shreg.sv | 36 +++
 rtl/seq_pattern_tx.sv | 112 +++++++++++
 tb/tb_seq_pattern_tx.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and default sizes.
package seq_pattern_tx_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefLenW  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle between a pattern source (master) and the transmitter (slave).
interface seq_pattern_tx_if
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned LenW  = DefLenW
) ();

  logic             start;
  logic [Width-1:0] pattern;
  logic [LenW-1:0]  length;
  logic             loop;
  logic             bit_en;
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, pattern, length, loop, bit_en,
    input  w, valid, busy, done, err
  );

  modport slave (
    input  start, pattern, length, loop, bit_en,
    output w, valid, busy, done, err
  );

endinterface

// File: rtl/seq_pattern_tx_shreg.sv
// Parallel-load, left-shift register with zero fill; MSB is the serial output bit.
module seq_pattern_tx_shreg
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [Width-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_val_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[Width-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a right-aligned pattern MSB-first, optionally looping.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned LenW  = DefLenW
) (
  input  logic            clock,
  input  logic            resetn,
  seq_pattern_tx_if.slave tx_io
);

  localparam logic [LenW:0] WidthExt = (LenW + 1)'(Width);

  state_e           state_q, state_d;
  logic [Width-1:0] pat_q, pat_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [LenW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             load, shift_en, msb, len_ok;
  logic [Width-1:0] load_pat, load_val;
  logic [LenW-1:0]  load_len;
  logic [LenW:0]    shamt;

  assign len_ok   = (tx_io.length != '0) && ({1'b0, tx_io.length} <= WidthExt);
  // Left-justify so the first bit to send lands in the MSB.
  assign shamt    = WidthExt - {1'b0, load_len};
  assign load_val = load_pat << shamt;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    load_pat = tx_io.pattern;
    load_len = tx_io.length;
    unique case (state_q)
      StIdle: begin
        if (tx_io.start) begin
          if (len_ok) begin
            pat_d   = tx_io.pattern;
            len_d   = tx_io.length;
            cnt_d   = tx_io.length;
            load    = 1'b1;
            state_d = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (tx_io.bit_en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - LenW'(1);
          if (cnt_q == LenW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (tx_io.loop) begin
          load_pat = pat_q;
          load_len = len_q;
          load     = 1'b1;
          cnt_d    = len_q;
          state_d  = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  seq_pattern_tx_shreg #(
    .Width (Width)
  ) u_shreg (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .load_i     (load),
    .load_val_i (load_val),
    .shift_i    (shift_en),
    .msb_o      (msb)
  );

  assign tx_io.valid = (state_q == StShift) && tx_io.bit_en;
  assign tx_io.w     = tx_io.valid && msb;
  assign tx_io.busy  = (state_q != StIdle);
  assign tx_io.done  = (state_q == StDone);
  assign tx_io.err   = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Cycle-by-cycle vector bench for seq_pattern_tx; expected outputs are hand-derived per cycle.
module tb_seq_pattern_tx;

  logic clock = 1'b0;
  logic resetn;

  seq_pattern_tx_if #(.Width(8), .LenW(4)) tx_if ();

  seq_pattern_tx #(
    .Width (8),
    .LenW  (4)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .tx_io  (tx_if)
  );

  always #5 clock = ~clock;

  // exp packs {w, valid, busy, done, err} for the cycle the inputs are applied in.
  typedef struct packed {
    logic [3:0] tid;
    logic       rstn;
    logic       start;
    logic [7:0] pat;
    logic [3:0] len;
    logic       loop;
    logic       en;
    logic [4:0] exp;
  } vec_t;

  typedef struct packed {
    logic [3:0]  tid;
    logic [15:0] idx;
    logic [4:0]  exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic run_done = 1'b0;

  task automatic add(input logic [3:0] tid, input logic rstn, input logic start,
                     input logic [7:0] pat, input logic [3:0] len, input logic loop,
                     input logic en, input logic [4:0] exp);
    vec_t v;
    v = '{tid: tid, rstn: rstn, start: start, pat: pat, len: len, loop: loop, en: en, exp: exp};
    vecs.push_back(v);
  endtask

  initial begin
    repeat (1000) @(posedge clock);
    if (!run_done) begin
      errors++;
      $display("FAIL timeout: vector run did not complete within 1000 cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [7:0] a5;
    logic [4:0] got;
    sb_t        e;

    // Reset state
    add(0, 1, 0, 8'h00, 4'd0, 0, 0, 5'b00000);

    // 0x0D, length 4, bit_en tied high: 1,1,0,1 then done
    add(1, 1, 1, 8'h0D, 4'd4, 0, 1, 5'b00000);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b11100);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b11100);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b01100);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b11100);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b00110);
    add(1, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b00000);

    // Alternate bit_en; start/pattern/length changes while busy must be ignored
    add(2, 1, 1, 8'h0D, 4'd4, 0, 0, 5'b00000);
    add(2, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b11100);
    add(2, 1, 1, 8'hFF, 4'd2, 0, 0, 5'b00100);
    add(2, 1, 1, 8'hFF, 4'd2, 0, 1, 5'b11100);
    add(2, 1, 1, 8'hFF, 4'd2, 0, 0, 5'b00100);
    add(2, 1, 1, 8'hFF, 4'd2, 0, 1, 5'b01100);
    add(2, 1, 1, 8'hFF, 4'd2, 0, 0, 5'b00100);
    add(2, 1, 0, 8'h0D, 4'd4, 0, 1, 5'b11100);
    add(2, 1, 0, 8'h0D, 4'd4, 0, 0, 5'b00110);
    add(2, 1, 0, 8'h0D, 4'd4, 0, 0, 5'b00000);

    // Loop 0x0F x3; loop dropped during the third pass
    add(3, 1, 1, 8'h0F, 4'd4, 1, 1, 5'b00000);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) add(3, 1, 0, 8'h0F, 4'd4, (p < 2), 1, 5'b11100);
      add(3, 1, 0, 8'h0F, 4'd4, (p < 2), 1, 5'b00110);
    end
    add(3, 1, 0, 8'h0F, 4'd4, 0, 1, 5'b00000);

    // Illegal lengths 0, 9, 15: one-cycle err, never busy
    add(4, 1, 1, 8'hFF, 4'd0, 0, 1, 5'b00000);
    add(4, 1, 0, 8'hFF, 4'd0, 0, 1, 5'b00001);
    add(4, 1, 1, 8'hFF, 4'd9, 0, 1, 5'b00000);
    add(4, 1, 0, 8'hFF, 4'd9, 0, 1, 5'b00001);
    add(4, 1, 1, 8'hFF, 4'd15, 0, 1, 5'b00000);
    add(4, 1, 0, 8'hFF, 4'd15, 0, 1, 5'b00001);
    add(4, 1, 0, 8'hFF, 4'd9, 0, 1, 5'b00000);

    // 0xA5 length 8, reset after two bits, then a full restart
    add(5, 1, 1, 8'hA5, 4'd8, 0, 1, 5'b00000);
    add(5, 1, 0, 8'hA5, 4'd8, 0, 1, 5'b11100);
    add(5, 1, 0, 8'hA5, 4'd8, 0, 1, 5'b01100);
    add(5, 0, 0, 8'hA5, 4'd8, 0, 1, 5'b11100);
    add(5, 1, 0, 8'hA5, 4'd8, 0, 1, 5'b00000);
    add(5, 1, 1, 8'hA5, 4'd8, 0, 1, 5'b00000);
    a5 = 8'hA5;
    for (int b = 7; b >= 0; b--) add(5, 1, 0, 8'hA5, 4'd8, 0, 1, {a5[b], 4'b1100});
    add(5, 1, 0, 8'hA5, 4'd8, 0, 1, 5'b00110);
    add(5, 1, 0, 8'hA5, 4'd8, 0, 1, 5'b00000);

    // start held high, length 1: SHIFT, DONE, IDLE, repeat
    add(6, 1, 1, 8'h01, 4'd1, 0, 1, 5'b00000);
    add(6, 1, 1, 8'h01, 4'd1, 0, 1, 5'b11100);
    add(6, 1, 1, 8'h01, 4'd1, 0, 1, 5'b00110);
    add(6, 1, 1, 8'h01, 4'd1, 0, 1, 5'b00000);
    add(6, 1, 1, 8'h01, 4'd1, 0, 1, 5'b11100);
    add(6, 1, 0, 8'h01, 4'd1, 0, 1, 5'b00110);
    add(6, 1, 0, 8'h01, 4'd1, 0, 1, 5'b00000);
    add(6, 1, 0, 8'h01, 4'd1, 0, 1, 5'b00000);

    resetn         = 1'b0;
    tx_if.start    = 1'b0;
    tx_if.pattern  = '0;
    tx_if.length   = '0;
    tx_if.loop     = 1'b0;
    tx_if.bit_en   = 1'b0;
    repeat (2) @(posedge clock);

    @(negedge clock);
    got = {tx_if.w, tx_if.valid, tx_if.busy, tx_if.done, tx_if.err};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset state {w,valid,busy,done,err} got %b want 00000", got);
    end
    @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      // Inputs for the row are applied just after an edge and held for the cycle.
      #1;
      resetn        = vecs[i].rstn;
      tx_if.start   = vecs[i].start;
      tx_if.pattern = vecs[i].pat;
      tx_if.length  = vecs[i].len;
      tx_if.loop    = vecs[i].loop;
      tx_if.bit_en  = vecs[i].en;
      sb_q.push_back('{tid: vecs[i].tid, idx: 16'(i), exp: vecs[i].exp});
      @(negedge clock);
      got = {tx_if.w, tx_if.valid, tx_if.busy, tx_if.done, tx_if.err};
      e   = sb_q.pop_front();
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL t%0d row%0d {w,valid,busy,done,err} got %b want %b",
                 e.tid, e.idx, got, e.exp);
      end
      @(posedge clock);
    end

    run_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
